dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-requester controller that shares the single-port DataMemory (32 x 64-bit doublewords, byte-addressed, 8-byte aligned) between requester 0 (core MEM stage) and requester 1 (debug/loader port).
- Arbitrates round-robin and sequences each access as a single MemRead/MemWrite strobe.
- Checks alignment and range before touching memory, and returns data or an error through a valid/ready response handshake.
- Sits between the requesters and DataMemory; it is the only driver of DataMemory's address, writeData, MemWrite and MemRead.

Parameters:
ADDR_W, 64, requester and memory address width
DATA_W, 64, data width
DEPTH, 32, memory depth in doublewords; legal byte addresses are 0 .. DEPTH*8-8

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
rN_req_valid  in  1  (N = 0,1) request present
rN_req_ready  out  1  request accepted this cycle
rN_req_write  in  1  1 = store, 0 = load
rN_req_addr  in  ADDR_W  byte address
rN_req_wdata  in  DATA_W  store data
rN_rsp_valid  out  1  response present
rN_rsp_ready  in  1  requester takes response
rN_rsp_rdata  out  DATA_W  load data; 0 for stores and errors
rN_rsp_err  out  1  misaligned or out-of-range access
mem_address  out  ADDR_W  to DataMemory address
mem_writeData  out  DATA_W  to DataMemory writeData
mem_MemWrite  out  1  to DataMemory MemWrite
mem_MemRead  out  1  to DataMemory MemRead
mem_readData  in  DATA_W  from DataMemory readData; combinational, valid in the same cycle as MemRead

Behaviour:
- Reset values: state IDLE; priority pointer selects requester 0; all req_ready, rsp_valid, rsp_err, mem_MemWrite and mem_MemRead are 0; rsp_rdata, mem_address and mem_writeData are 0.
- FSM has three states: IDLE, ISSUE, RESP. One transaction is outstanding at a time.
- IDLE:
  - Grant goes to the valid requester. If both are valid, the pointer decides.
  - rN_req_ready is asserted combinationally for the granted requester only. A handshake occurs when valid and ready are both high.
  - On handshake, latch write, addr, wdata and the grant id.
  - If addr[2:0] != 0 or addr >= DEPTH*8 (full-width unsigned compare), latch err=1 and go to RESP without a memory access. Otherwise go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Drive mem_address and mem_writeData from the latched command.
  - Assert mem_MemWrite = cmd_write & ~reset, or mem_MemRead = ~cmd_write & ~reset.
  - For a load, register mem_readData into rsp_rdata at the end of the cycle. For a store, rsp_rdata = 0.
  - Go to RESP.
- RESP:
  - Assert rsp_valid and rsp_err/rsp_rdata to the granted requester only. Hold them stable until rsp_ready.
  - On rsp_ready, go to IDLE and set the pointer to the other requester.
  - No req_ready is asserted in RESP.
- Latency:
  - Accept at cycle T, memory strobe at T+1, rsp_valid at T+2.
  - Error path: rsp_valid at T+1.
  - Next accept is no earlier than the cycle after the response handshake.
- Memory strobes are 0 in every state except ISSUE. MemRead and MemWrite are never both 1.
- Fairness: with both requesters continuously valid, grants strictly alternate 0,1,0,1...
- req_valid deasserting before a grant is legal and nothing is latched. Request fields are ignored once latched.
- Reset mid-operation:
  - Abort the transaction and return to the reset state next cycle.
  - No write commits on a cycle where reset=1, because the strobes are gated by ~reset.
  - A pending response is dropped.
- Error response: rsp_err=1, rsp_rdata=0, memory untouched.

Decomposition:
- Package dmem_ctrl_pkg holds:
  - state enum {IDLE, ISSUE, RESP}
  - DEPTH, ADDR_W and DATA_W defaults
  - requester id type (1 bit)
  - function addr_ok(addr), which checks alignment and range
- Sub-module rr_arb2 holds the 2-way round-robin grant: inputs req[1:0], advance and the pointer register; outputs a one-hot grant. It is reusable for other shared resources.

Test Plan:
- Reset, then r0 load at addr 0x0 -> mem_MemRead pulses exactly 1 cycle at T+1; r0_rsp_valid at T+2 with rdata = Memory[0], err=0.
- r1 store 0xDEADBEEFCAFEBABE at 0x10, then r0 load 0x10 -> store response rdata=0, err=0; load returns 0xDEADBEEFCAFEBABE.
- r0 load at 0x4 (misaligned) and r1 load at 0x100 (= DEPTH*8) -> rsp_err=1, rdata=0, with no MemRead/MemWrite pulse and rsp_valid at T+1.
- Both requesters valid continuously with 4 loads each at 0x0,0x8,0x10,0x18 -> grants alternate 0,1,0,1...; exactly 8 strobes; each response is routed only to its owner.
- rsp_ready held low for 5 cycles in RESP -> rsp_valid and rdata held stable; no new req_ready; no strobe.
- Assert reset during ISSUE of a store of 0x1234 at 0x18 -> mem_MemWrite=0 on that cycle; Memory[3] unchanged on readback; all outputs at reset values the next cycle.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared types and helpers for the DataMemory access controller.
// Holds the FSM state encoding, default widths and the address legality check.
package dmem_ctrl_pkg;

   localparam int unsigned DefAddrW = 64;
   localparam int unsigned DefDataW = 64;
   localparam int unsigned DefDepth = 32;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StResp
   } state_e;

   typedef logic req_id_t;

   // Legal when doubleword aligned and below depth*8, compared at full width.
   function automatic logic addr_ok(logic [DefAddrW-1:0] addr, int unsigned depth);
      logic [DefAddrW-1:0] limit;
      limit = DefAddrW'(depth) << 3;
      return (addr[2:0] == 3'b000) && (addr < limit);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a one-hot grant.
// The pointer picks the winner on contention and moves past the owner on advance.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req_i,
   input  logic       advance_i,
   input  logic       owner_i,
   output logic [1:0] gnt_o
);

   logic ptr_q, ptr_d;

   always_comb begin
      gnt_o = 2'b00;
      unique case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
         default: gnt_o = 2'b00;
      endcase
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance_i) begin
         ptr_d = ~owner_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port DataMemory between two requesters, one access at a time.
// Each access is checked, issued as a single strobe cycle and answered via valid/ready.
module dmem_arbiter
   import dmem_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = DefAddrW,
   parameter int unsigned DATA_W = DefDataW,
   parameter int unsigned DEPTH  = DefDepth
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              r0_req_valid,
   output logic              r0_req_ready,
   input  logic              r0_req_write,
   input  logic [ADDR_W-1:0] r0_req_addr,
   input  logic [DATA_W-1:0] r0_req_wdata,
   output logic              r0_rsp_valid,
   input  logic              r0_rsp_ready,
   output logic [DATA_W-1:0] r0_rsp_rdata,
   output logic              r0_rsp_err,

   input  logic              r1_req_valid,
   output logic              r1_req_ready,
   input  logic              r1_req_write,
   input  logic [ADDR_W-1:0] r1_req_addr,
   input  logic [DATA_W-1:0] r1_req_wdata,
   output logic              r1_rsp_valid,
   input  logic              r1_rsp_ready,
   output logic [DATA_W-1:0] r1_rsp_rdata,
   output logic              r1_rsp_err,

   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_writeData,
   output logic              mem_MemWrite,
   output logic              mem_MemRead,
   input  logic [DATA_W-1:0] mem_readData
);

   state_e              state_q, state_d;
   logic                cmd_write_q, cmd_write_d;
   logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
   logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
   req_id_t             cmd_id_q, cmd_id_d;
   logic                cmd_err_q, cmd_err_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic [1:0]          req_vec;
   logic [1:0]          gnt;
   logic                advance;
   logic                sel_write;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic [DefAddrW-1:0] chk_addr;
   logic                sel_ok;
   logic                rsp_ready_sel;
   logic                in_issue;
   logic                in_resp;

   // Requests are only offered to the arbiter while no transaction is outstanding.
   assign req_vec = {r1_req_valid, r0_req_valid} & {2{state_q == StIdle}};

   rr_arb2 u_rr_arb2 (
      .clk       (clk),
      .reset     (reset),
      .req_i     (req_vec),
      .advance_i (advance),
      .owner_i   (cmd_id_q),
      .gnt_o     (gnt)
   );

   assign sel_write = gnt[1] ? r1_req_write : r0_req_write;
   assign sel_addr  = gnt[1] ? r1_req_addr  : r0_req_addr;
   assign sel_wdata = gnt[1] ? r1_req_wdata : r0_req_wdata;
   assign chk_addr  = DefAddrW'(sel_addr);
   assign sel_ok    = addr_ok(chk_addr, DEPTH);

   assign rsp_ready_sel = cmd_id_q ? r1_rsp_ready : r0_rsp_ready;

   always_comb begin
      state_d     = state_q;
      cmd_write_d = cmd_write_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_wdata_d = cmd_wdata_q;
      cmd_id_d    = cmd_id_q;
      cmd_err_d   = cmd_err_q;
      rdata_d     = rdata_q;
      advance     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (|gnt) begin
               cmd_write_d = sel_write;
               cmd_addr_d  = sel_addr;
               cmd_wdata_d = sel_wdata;
               cmd_id_d    = gnt[1];
               cmd_err_d   = ~sel_ok;
               rdata_d     = '0;
               state_d     = sel_ok ? StIssue : StResp;
            end
         end
         StIssue: begin
            rdata_d = cmd_write_q ? '0 : mem_readData;
            state_d = StResp;
         end
         StResp: begin
            if (rsp_ready_sel) begin
               advance = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         cmd_write_q <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         cmd_id_q    <= 1'b0;
         cmd_err_q   <= 1'b0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         cmd_write_q <= cmd_write_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_wdata_q <= cmd_wdata_d;
         cmd_id_q    <= cmd_id_d;
         cmd_err_q   <= cmd_err_d;
         rdata_q     <= rdata_d;
      end
   end

   assign in_issue = (state_q == StIssue);
   assign in_resp  = (state_q == StResp);

   assign r0_req_ready = gnt[0];
   assign r1_req_ready = gnt[1];

   assign r0_rsp_valid = in_resp & ~cmd_id_q;
   assign r1_rsp_valid = in_resp & cmd_id_q;
   assign r0_rsp_err   = r0_rsp_valid & cmd_err_q;
   assign r1_rsp_err   = r1_rsp_valid & cmd_err_q;
   assign r0_rsp_rdata = r0_rsp_valid ? rdata_q : '0;
   assign r1_rsp_rdata = r1_rsp_valid ? rdata_q : '0;

   // Gating by reset keeps an aborted access from committing on the reset cycle.
   assign mem_address   = in_issue ? cmd_addr_q : '0;
   assign mem_writeData = in_issue ? cmd_wdata_q : '0;
   assign mem_MemWrite  = in_issue & cmd_write_q & ~reset;
   assign mem_MemRead   = in_issue & ~cmd_write_q & ~reset;

endmodule
